// File: rtl/kbest_layer_engine.sv
`timescale 1ns/1ps
// K-best sphere-decoder layer: expands K parent paths into 4 PAM children each
// and keeps the K smallest partial Euclidean distances as an ascending list.
module kbest_layer_engine #(
   parameter int N      = 2,
   parameter int K      = 4,
   parameter int WL     = 16,
   parameter int FWL    = 12,
   parameter int ERR_WL = 16,
   parameter int ERR_FWL = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [N*WL-1:0]        r_row,
   input  logic [WL-1:0]          y,
   input  logic [K*(N-1)*2-1:0]   path_in,
   input  logic [K*ERR_WL-1:0]    ped_in,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [K*N*2-1:0]       path_out,
   output logic [K*ERR_WL-1:0]    ped_out,
   output logic                   out_sat
);
   localparam int  PW       = (N-1)*2;
   localparam int  CW       = N*2;
   localparam int  M        = K+4;
   localparam int  CNT_W    = (K > 1) ? $clog2(K) : 1;
   localparam int  SH_P     = 2*FWL - ERR_FWL;
   localparam int  SH_Y     = FWL - ERR_FWL;
   localparam real INV_SQ10 = 0.31622776601683794;
   localparam int  LV1      = int'($rtoi(INV_SQ10 * (2.0 ** FWL) + 0.5));
   localparam int  LV3      = int'($rtoi(3.0 * INV_SQ10 * (2.0 ** FWL) + 0.5));

   typedef enum logic [1:0] {IDLE, EXPAND, DRAIN, OUTPUT} state_t;

   function automatic logic signed [WL-1:0] lvl(input logic [1:0] s);
      case (s)
         2'b10:   lvl = WL'(-LV3);
         2'b11:   lvl = WL'(-LV1);
         2'b01:   lvl = WL'(LV1);
         default: lvl = WL'(LV3);
      endcase
   endfunction

   // Child index 0..3 walks the levels -3, -1, +1, +3.
   function automatic logic [1:0] csym(input int c);
      case (c)
         0:       csym = 2'b10;
         1:       csym = 2'b11;
         2:       csym = 2'b01;
         default: csym = 2'b00;
      endcase
   endfunction

   function automatic logic signed [ERR_WL-1:0] prod(input logic signed [WL-1:0] r,
                                                     input logic signed [WL-1:0] c);
      logic signed [2*WL-1:0] p;
      p    = (2*WL)'(r) * (2*WL)'(c);
      prod = ERR_WL'(p >>> SH_P);
   endfunction

   state_t                         state_q, state_d;
   logic [N*WL-1:0]                r_q, r_d;
   logic signed [WL-1:0]           y_q, y_d;
   logic [K*PW-1:0]                path_q, path_d;
   logic [K*ERR_WL-1:0]            ped_q, ped_d;
   logic [CNT_W-1:0]               cnt_q, cnt_d;
   logic                           stg_vld_q, stg_vld_d;
   logic [3:0][ERR_WL-1:0]         stg_err_q, stg_err_d;
   logic [ERR_WL-1:0]              stg_ped_q, stg_ped_d;
   logic [PW-1:0]                  stg_path_q, stg_path_d;
   logic [K-1:0]                   lst_vld_q, lst_vld_d;
   logic [K-1:0]                   lst_sat_q, lst_sat_d;
   logic [K-1:0][ERR_WL-1:0]       lst_ped_q, lst_ped_d;
   logic [K-1:0][CW-1:0]           lst_path_q, lst_path_d;
   logic                           sat_q, sat_d;

   logic [PW-1:0]                  par_path;
   logic [ERR_WL-1:0]              par_ped;
   logic signed [ERR_WL-1:0]       ys, sum;
   logic [3:0][ERR_WL-1:0]         err_n;

   logic signed [2*ERR_WL-1:0]     e2 [4];
   logic [2*ERR_WL:0]              tot [4];
   logic [3:0]                     ch_sat;
   logic                           cv [M];
   logic                           cs [M];
   logic [ERR_WL-1:0]              cp [M];
   logic [CW-1:0]                  cpath [M];
   int                             rk [M];
   logic [K-1:0]                   mrg_vld, mrg_sat;
   logic [K-1:0][ERR_WL-1:0]       mrg_ped;
   logic [K-1:0][CW-1:0]           mrg_path;
   logic                           ins_sat;

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == OUTPUT);
   assign path_out  = lst_path_q;
   assign ped_out   = lst_ped_q;
   assign out_sat   = sat_q;

   // Issue stage: interference and per-child error for the parent under cnt_q.
   always_comb begin
      par_path = path_q[int'(cnt_q)*PW +: PW];
      par_ped  = ped_q[int'(cnt_q)*ERR_WL +: ERR_WL];
      ys       = ERR_WL'(y_q >>> SH_Y);
      sum      = '0;
      for (int j = 1; j < N; j++)
         sum = sum + prod(r_q[j*WL +: WL], lvl(par_path[2*j-2 +: 2]));
      for (int c = 0; c < 4; c++)
         err_n[c] = ys - prod(r_q[WL-1:0], lvl(csym(c))) - sum;
   end

   // Insert stage. A saturated PED carries its flag as the key MSB, so it ranks
   // behind an exact all-ones PED. Rank = number of candidates that precede it.
   always_comb begin
      for (int i = 0; i < K; i++) begin
         cv[i]    = lst_vld_q[i];
         cs[i]    = lst_sat_q[i];
         cp[i]    = lst_ped_q[i];
         cpath[i] = lst_path_q[i];
      end
      for (int c = 0; c < 4; c++) begin
         e2[c]     = (2*ERR_WL)'($signed(stg_err_q[c])) * (2*ERR_WL)'($signed(stg_err_q[c]));
         tot[c]    = (2*ERR_WL+1)'($unsigned(e2[c] >>> ERR_FWL)) + (2*ERR_WL+1)'(stg_ped_q);
         ch_sat[c] = |tot[c][2*ERR_WL:ERR_WL];
         cv[K+c]    = stg_vld_q;
         cs[K+c]    = ch_sat[c];
         cp[K+c]    = ch_sat[c] ? '1 : tot[c][ERR_WL-1:0];
         cpath[K+c] = {stg_path_q, csym(c)};
      end
      for (int i = 0; i < M; i++) begin
         rk[i] = 0;
         for (int j = 0; j < M; j++) begin
            if (j != i && ((cv[j] && !cv[i]) ||
                           (cv[j] == cv[i] && (({cs[j], cp[j]} < {cs[i], cp[i]}) ||
                                               ({cs[j], cp[j]} == {cs[i], cp[i]} && j < i)))))
               rk[i] = rk[i] + 1;
         end
      end
      mrg_vld  = '0;
      mrg_sat  = '0;
      mrg_ped  = '0;
      mrg_path = '0;
      for (int s = 0; s < K; s++) begin
         for (int i = 0; i < M; i++) begin
            if (rk[i] == s) begin
               mrg_vld[s]  = cv[i];
               mrg_sat[s]  = cs[i];
               mrg_ped[s]  = cp[i];
               mrg_path[s] = cpath[i];
            end
         end
      end
      ins_sat = stg_vld_q && (|ch_sat);
   end

   always_comb begin
      state_d    = state_q;
      r_d        = r_q;
      y_d        = y_q;
      path_d     = path_q;
      ped_d      = ped_q;
      cnt_d      = cnt_q;
      stg_vld_d  = 1'b0;
      stg_err_d  = stg_err_q;
      stg_ped_d  = stg_ped_q;
      stg_path_d = stg_path_q;
      lst_vld_d  = lst_vld_q;
      lst_sat_d  = lst_sat_q;
      lst_ped_d  = lst_ped_q;
      lst_path_d = lst_path_q;
      sat_d      = sat_q;
      if (stg_vld_q) begin
         lst_vld_d  = mrg_vld;
         lst_sat_d  = mrg_sat;
         lst_ped_d  = mrg_ped;
         lst_path_d = mrg_path;
         sat_d      = sat_q | ins_sat;
      end
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               r_d        = r_row;
               y_d        = y;
               path_d     = path_in;
               ped_d      = ped_in;
               cnt_d      = '0;
               lst_vld_d  = '0;
               lst_sat_d  = '0;
               lst_ped_d  = '0;
               lst_path_d = '0;
               sat_d      = 1'b0;
               state_d    = EXPAND;
            end
         end
         EXPAND: begin
            stg_vld_d  = 1'b1;
            stg_err_d  = err_n;
            stg_ped_d  = par_ped;
            stg_path_d = par_path;
            cnt_d      = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(K-1)) state_d = DRAIN;
         end
         DRAIN:   if (!stg_vld_q) state_d = OUTPUT;
         OUTPUT:  if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         r_q        <= '0;
         y_q        <= '0;
         path_q     <= '0;
         ped_q      <= '0;
         cnt_q      <= '0;
         stg_vld_q  <= 1'b0;
         stg_err_q  <= '0;
         stg_ped_q  <= '0;
         stg_path_q <= '0;
         lst_vld_q  <= '0;
         lst_sat_q  <= '0;
         lst_ped_q  <= '0;
         lst_path_q <= '0;
         sat_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         r_q        <= r_d;
         y_q        <= y_d;
         path_q     <= path_d;
         ped_q      <= ped_d;
         cnt_q      <= cnt_d;
         stg_vld_q  <= stg_vld_d;
         stg_err_q  <= stg_err_d;
         stg_ped_q  <= stg_ped_d;
         stg_path_q <= stg_path_d;
         lst_vld_q  <= lst_vld_d;
         lst_sat_q  <= lst_sat_d;
         lst_ped_q  <= lst_ped_d;
         lst_path_q <= lst_path_d;
         sat_q      <= sat_d;
      end
   end

endmodule

// File: tb/tb_kbest_layer_engine.sv
`timescale 1ns/1ps
// Directed bench for kbest_layer_engine at N=2, K=4 with hand-derived survivor lists.
module tb_kbest_layer_engine;
   localparam int N = 2, K = 4, WL = 16, FWL = 12, ERR_WL = 16, ERR_FWL = 8;

   logic                  clk = 1'b0;
   logic                  rst = 1'b0;
   logic                  in_valid = 1'b0;
   logic                  in_ready;
   logic [N*WL-1:0]       r_row = '0;
   logic [WL-1:0]         y = '0;
   logic [K*(N-1)*2-1:0]  path_in = '0;
   logic [K*ERR_WL-1:0]   ped_in = '0;
   logic                  out_valid;
   logic                  out_ready = 1'b0;
   logic [K*N*2-1:0]      path_out;
   logic [K*ERR_WL-1:0]   ped_out;
   logic                  out_sat;

   kbest_layer_engine #(.N(N), .K(K), .WL(WL), .FWL(FWL), .ERR_WL(ERR_WL), .ERR_FWL(ERR_FWL)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .r_row(r_row), .y(y), .path_in(path_in), .ped_in(ped_in),
      .out_valid(out_valid), .out_ready(out_ready),
      .path_out(path_out), .ped_out(ped_out), .out_sat(out_sat));

   always #5 clk = ~clk;

   // Vectors: parents p0..p3 = 10,11,01,00 with R_ii = 1.0, y = +3 level.
   localparam logic [31:0] R_PIV  = 32'h0000_1000;
   localparam logic [31:0] R_INT  = 32'h1000_1000;
   localparam logic [15:0] Y_P3   = 16'd3886;
   localparam logic [15:0] Y_INT  = 16'd7772;
   localparam logic [7:0]  P_ORD  = 8'b00_01_11_10;
   localparam logic [63:0] PED_A  = 64'h001E_0014_000A_0000;
   localparam logic [63:0] PED_0  = 64'h0;
   localparam logic [63:0] PED_F  = 64'hFFFF_FFFF_FFFF_FFFF;
   localparam logic [63:0] PED_I  = 64'h012C_00C8_0064_0000;
   localparam logic [15:0] PTH_A  = 16'h04C8;
   localparam logic [63:0] EPED_I = 64'h00C8_0067_0064_0000;
   localparam logic [15:0] PTH_I  = 16'h0100;

   int n_chk = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic send(input logic [31:0] rr, input logic [15:0] yy,
                       input logic [7:0] pp, input logic [63:0] pd);
      @(negedge clk);
      r_row = rr; y = yy; path_in = pp; ped_in = pd; in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic wait_out(input string tag);
      int lat;
      lat = 0;
      while (!out_valid && lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check({tag, " latency"}, 64'(lat), 64'd6);
   endtask

   task automatic release_out(input string tag);
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      check({tag, " back to idle"}, {62'd0, out_valid, in_ready}, 64'b01);
   endtask

   task automatic run_vec(input string tag, input logic [31:0] rr, input logic [15:0] yy,
                          input logic [7:0] pp, input logic [63:0] pd,
                          input logic [63:0] eped, input logic [15:0] epath, input logic esat);
      send(rr, yy, pp, pd);
      wait_out(tag);
      check({tag, " ped_out"}, ped_out, eped);
      check({tag, " path_out"}, 64'(path_out), 64'(epath));
      check({tag, " out_sat"}, 64'(out_sat), 64'(esat));
      release_out(tag);
   endtask

   task automatic check_zero(input string tag);
      check({tag, " in_ready"}, 64'(in_ready), 64'd1);
      check({tag, " out_valid"}, 64'(out_valid), 64'd0);
      check({tag, " ped_out"}, ped_out, 64'd0);
      check({tag, " path_out"}, 64'(path_out), 64'd0);
      check({tag, " out_sat"}, 64'(out_sat), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      repeat (3) @(negedge clk);
      check_zero("reset");
      rst = 1'b1;

      run_vec("order", R_PIV, Y_P3, P_ORD, PED_A, PED_A, PTH_A, 1'b0);
      run_vec("tie",   R_PIV, Y_P3, P_ORD, PED_0, PED_0, PTH_A, 1'b0);
      run_vec("sat",   R_PIV, Y_P3, P_ORD, PED_F, PED_F, PTH_A, 1'b1);
      run_vec("intf",  R_INT, Y_INT, 8'h00, PED_I, EPED_I, PTH_I, 1'b0);

      // Backpressure: results hold while a competing vector is offered.
      send(R_PIV, Y_P3, P_ORD, PED_A);
      wait_out("bp");
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         r_row = R_PIV; y = Y_P3; path_in = P_ORD; ped_in = PED_F; in_valid = 1'b1;
         @(posedge clk);
         #1;
         check("bp ped_out", ped_out, PED_A);
         check("bp path_out", 64'(path_out), 64'(PTH_A));
         check("bp in_ready", 64'(in_ready), 64'd0);
         check("bp out_valid", 64'(out_valid), 64'd1);
      end
      in_valid = 1'b0;
      check("bp out_sat", 64'(out_sat), 64'd0);
      release_out("bp");

      // Reset in the middle of expansion, then a clean vector.
      send(R_PIV, Y_P3, P_ORD, PED_F);
      @(posedge clk);
      #1;
      check("abort in_ready", 64'(in_ready), 64'd0);
      @(posedge clk);
      #1;
      check("abort sticky sat", 64'(out_sat), 64'd1);
      rst = 1'b0;
      #1;
      check_zero("abort");
      @(negedge clk);
      rst = 1'b1;
      run_vec("post-reset", R_PIV, Y_P3, P_ORD, PED_A, PED_A, PTH_A, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/kbest_layer_engine.md
KBEST_LAYER_ENGINE -- requirements
Module: kbest_layer_engine

Interface
REQ-001 SHALL have these parameters:
- N, 2, layer depth: N-1 decided symbols plus 1 new symbol; legal range 2..4.
- K, 4, survivor count; legal range 1..16.
- WL, 16, R/Y word length.
- FWL, 12, R/Y fraction bits.
- ERR_WL, 16, error/PED word length.
- ERR_FWL, 8, error/PED fraction bits.

REQ-002 SHALL have these ports (reset rst, asynchronous, active-low; clock clk):
- clk  in  1  clock.
- rst  in  1  asynchronous active-low reset.
- in_valid  in  1  input vector valid.
- in_ready  out  1  engine can accept.
- r_row  in  N*WL  signed R row; slice 0 is pivot R_ii; slice j (1..N-1) is R for decided symbol j.
- y  in  WL  signed rotated receive sample.
- path_in  in  K*(N-1)*2  parent p at bits [(p+1)(N-1)*2-1 : p(N-1)*2]; symbol j at bits [2j-1:2j-2] within the parent.
- ped_in  in  K*ERR_WL  unsigned parent PEDs, parent p in slice p.
- out_valid  out  1  survivor list valid.
- out_ready  in  1  consumer accepts.
- path_out  out  K*N*2  survivor s paths; new symbol in the low 2 bits of each entry.
- ped_out  out  K*ERR_WL  survivor PEDs, ascending, slice 0 smallest.
- out_sat  out  1  any PED saturation occurred in this vector.

Function
REQ-003 SHALL map 2-bit symbols (Gray) to 4-PAM levels as follows; Q-FWL constants -3886, -1295, 1295, 3886 at FWL=12, scaled as round(level/sqrt(10)*2^FWL):
- 10 = -3
- 11 = -1
- 01 = +1
- 00 = +3

REQ-004 SHALL compute every product as ((R*C)>>>FWL)>>>(FWL-ERR_FWL), truncated to ERR_WL; y SHALL be scaled as y>>>(FWL-ERR_FWL).

REQ-005 SHALL, per parent p, form interference sum over j=1..N-1 of prod(R_j, x_j) in ERR_WL with two's-complement wrap.

REQ-006 SHALL, per parent p and child c in {-3,-1,+1,+3}:
- err = y_s - prod(R_ii, c) - sum;
- child PED = ((err*err)>>>ERR_FWL) + ped_in[p];
- if the unsigned result exceeds 2^ERR_WL-1, the child PED saturates to all-ones and sets the sticky out_sat.

REQ-007 SHALL implement an FSM with states IDLE, EXPAND, DRAIN, OUTPUT; in_ready=1 only in IDLE.

REQ-008 IDLE: on in_valid&&in_ready, SHALL register r_row, y, path_in, ped_in, clear the survivor list (all entries invalid), clear out_sat, zero the parent counter, and go to EXPAND.

REQ-009 EXPAND: SHALL issue one parent per cycle (counter 0..K-1) into a one-stage register, computing err; after issuing parent K-1 it SHALL go to DRAIN.

REQ-010 The insert stage SHALL, one cycle after issue:
- square, add and saturate the parent's 4 child PEDs;
- merge them into the K-entry sorted list, keeping the K smallest valid entries ascending.

REQ-011 Merge ordering:
- invalid entries always lose;
- on equal PED, existing list entries precede new children;
- among new children, order is c=-3, -1, +1, +3.

REQ-012 DRAIN: SHALL perform the final insertion, then go to OUTPUT; out_valid SHALL rise exactly K+2 rising edges after the accepting edge.

REQ-013 OUTPUT: out_valid=1 with path_out/ped_out/out_sat stable until out_valid&&out_ready, then IDLE; in_valid while not in IDLE SHALL be ignored.

REQ-014 A child path SHALL be {parent path, new 2-bit symbol}.

REQ-015 When K<4 (list filled by parent 0 alone), later parents SHALL still be compared and may displace entries.

Reset
REQ-016 rst low SHALL, at any time including mid-EXPAND or OUTPUT, force IDLE, in_ready=1, out_valid=0, out_sat=0, path_out=0, ped_out=0, and all list entries invalid.

REQ-017 After rst release, the first accepting edge SHALL start a fresh vector with no residue of the aborted one.

Verification (K=4, N=2, defaults)
REQ-018 Ordering: R_ii=4096, R_1=0, y=3886, ped_in={0,10,20,30}, path_in=parents 10,11,01,00 -> ped_out={0,10,20,30}, path_out={1000,1100,0100,0000}, out_sat=0, out_valid at accept+6.

REQ-019 Tie: same as REQ-018 but ped_in all 0 -> ped_out all 0, path_out in parent order 0..3 each with symbol 00.

REQ-020 Saturation: ped_in all 65535, y=3886, R_ii=4096 -> ped_out all 65535, symbol 00 children of parents 0..3 in order, out_sat=1.

REQ-021 Backpressure: hold out_ready=0 for 5 cycles in OUTPUT -> outputs stable, in_ready=0, in_valid pulses ignored; out_ready=1 -> IDLE next edge.

REQ-022 Reset mid-EXPAND: assert rst at accept+2 -> outputs zero immediately; a new vector per REQ-018 then completes with the REQ-018 results.

REQ-023 Interference: R_1=4096, decided symbol 00 (+3), y=7772, R_ii=4096 -> best child symbol 00 with ped 0 (y_s=485, 2*242=484, err=1, 1>>>8=0).
